// File: rtl/fifo_defines_pkg.sv
// rtl/fifo_defines_pkg.sv - shared types and default sizes for the function generators
package fifo_defines_pkg;

  typedef enum logic [1:0] {IDLE, CONFI, GEN} state_t;
  typedef enum logic [1:0] {SINE, COSINE, TRIANGLE, SQUARE} wave_sel_t;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_AMP_WIDTH   = 8;
  localparam int DEF_LUT_ADDR    = 8;
  localparam int DEF_PHASE_WIDTH = 16;
  localparam int DEF_NUM_CH      = 2;

endpackage

// File: rtl/funct_gen_wave_rom.sv
// rtl/funct_gen_wave_rom.sv - synchronous dual-read sine ROM
// Contents are computed at elaboration; the real arithmetic never reaches hardware.
module funct_gen_wave_rom #(
  parameter int LUT_ADDR   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         i_en,
  input  logic [LUT_ADDR-1:0]          i_addr_a,
  input  logic [LUT_ADDR-1:0]          i_addr_b,
  output logic signed [DATA_WIDTH-1:0] o_data_a,
  output logic signed [DATA_WIDTH-1:0] o_data_b
);

  localparam int DEPTH = 2**LUT_ADDR;

  function automatic logic [DATA_WIDTH-1:0] sine_q(input int k);
    real pi, x, term, sum, scaled;
    int  r;
    pi = 3.14159265358979323846;
    x  = 2.0 * pi * real'(k) / real'(DEPTH);
    if (x > pi) x = x - 2.0 * pi;
    // Fold into [-pi/2, pi/2] so the Taylor series converges quickly
    if (x > pi / 2.0) x = pi - x;
    else if (x < -pi / 2.0) x = -pi - x;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scaled = sum * real'(2**(DATA_WIDTH-1) - 1);
    r = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
    return DATA_WIDTH'(r);
  endfunction

  logic [DATA_WIDTH-1:0] w_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] VAL = sine_q(k);
    assign w_rom[k] = VAL;
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_data_a <= $signed(w_rom[i_addr_a]);
      o_data_b <= $signed(w_rom[i_addr_b]);
    end
  end

endmodule

// File: rtl/funct_generator_mc.sv
// rtl/funct_generator_mc.sv - multi-channel LUT function generator feeding a FIFO write port
// Channels are issued round-robin into a 2-stage pipeline (ROM/select, then scale/saturate).
module funct_generator_mc
  import fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int AMP_WIDTH   = DEF_AMP_WIDTH,
  parameter int LUT_ADDR    = DEF_LUT_ADDR,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en_low_i,
  input  logic                                          enh_conf_i,
  input  logic                                          cfg_we_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
  input  logic [1:0]                                    cfg_sel_i,
  input  logic [AMP_WIDTH-1:0]                          cfg_amp_i,
  input  logic [PHASE_WIDTH-1:0]                        cfg_step_i,
  input  logic                                          cfg_en_i,
  input  logic                                          full_i,
  output logic                                          wr_en_o,
  output logic [DATA_WIDTH-1:0]                         data_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = DATA_WIDTH + AMP_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] FULL   = DATA_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic [DATA_WIDTH-1:0]        HALF   = DATA_WIDTH'(2**(DATA_WIDTH-1));
  localparam logic signed [PW-1:0]         SAT_HI = PW'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [PW-1:0]         SAT_LO = PW'(-(2**(DATA_WIDTH-1)));

  state_t                       r_state;
  logic [PHASE_WIDTH-1:0]       r_phase [NUM_CH];
  logic [PHASE_WIDTH-1:0]       r_step  [NUM_CH];
  logic signed [AMP_WIDTH-1:0]  r_amp   [NUM_CH];
  wave_sel_t                    r_sel   [NUM_CH];
  logic                         r_en    [NUM_CH];
  logic [CH_W-1:0]              r_ch_ptr;

  logic                         r_s1_valid;
  logic [CH_W-1:0]              r_s1_ch;
  wave_sel_t                    r_s1_sel;
  logic signed [AMP_WIDTH-1:0]  r_s1_amp;
  logic [DATA_WIDTH-1:0]        r_s1_u;
  logic                         r_s2_valid;
  logic [CH_W-1:0]              r_s2_ch;
  logic [DATA_WIDTH-1:0]        r_s2_data;

  logic                         w_run, w_adv;
  logic [PHASE_WIDTH-1:0]       w_p;
  logic [LUT_ADDR-1:0]          w_sin_addr, w_cos_addr;
  logic signed [DATA_WIDTH-1:0] w_rom_sin, w_rom_cos, w_wave;
  logic [DATA_WIDTH-2:0]        w_tri_t;
  logic signed [PW-1:0]         w_prod, w_res;
  logic [DATA_WIDTH-1:0]        w_sat;

  // Exit conditions gate the pipeline on the very edge the FSM leaves GEN
  assign w_run      = (r_state == GEN) && !enh_conf_i && !en_low_i;
  assign w_adv      = w_run && !full_i;
  assign w_p        = r_phase[r_ch_ptr];
  assign w_sin_addr = w_p[PHASE_WIDTH-1 -: LUT_ADDR];
  assign w_cos_addr = w_sin_addr + LUT_ADDR'(2**(LUT_ADDR-2));

  funct_gen_wave_rom #(
    .LUT_ADDR   (LUT_ADDR),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom (
    .clk      (clk),
    .i_en     (w_adv),
    .i_addr_a (w_sin_addr),
    .i_addr_b (w_cos_addr),
    .o_data_a (w_rom_sin),
    .o_data_b (w_rom_cos)
  );

  always_comb begin
    w_tri_t = r_s1_u[DATA_WIDTH-1] ? ~r_s1_u[DATA_WIDTH-2:0] : r_s1_u[DATA_WIDTH-2:0];
    w_wave  = w_rom_sin;
    case (r_s1_sel)
      SINE:     w_wave = w_rom_sin;
      COSINE:   w_wave = w_rom_cos;
      TRIANGLE: w_wave = $signed({w_tri_t, 1'b0} - HALF);
      default:  w_wave = r_s1_u[DATA_WIDTH-1] ? -FULL : FULL;
    endcase
    w_prod = PW'(w_wave) * PW'(r_s1_amp);
    w_res  = w_prod >>> (AMP_WIDTH - 1);
    w_sat  = w_res[DATA_WIDTH-1:0];
    if (w_res > SAT_HI)      w_sat = DATA_WIDTH'(SAT_HI);
    else if (w_res < SAT_LO) w_sat = DATA_WIDTH'(SAT_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ch_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_sel   <= SINE;
      r_s1_amp   <= '0;
      r_s1_u     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ch    <= '0;
      r_s2_data  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_phase[i] <= '0;
        r_step[i]  <= '0;
        r_amp[i]   <= '0;
        r_sel[i]   <= SINE;
        r_en[i]    <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE:    if (enh_conf_i) r_state <= CONFI;
                 else if (!en_low_i) r_state <= GEN;
        CONFI:   if (!enh_conf_i) r_state <= IDLE;
        GEN:     if (enh_conf_i || en_low_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (r_state == CONFI && cfg_we_i && int'(cfg_ch_i) < NUM_CH) begin
        r_sel[cfg_ch_i]  <= wave_sel_t'(cfg_sel_i);
        r_amp[cfg_ch_i]  <= $signed(cfg_amp_i);
        r_step[cfg_ch_i] <= cfg_step_i;
        r_en[cfg_ch_i]   <= cfg_en_i;
      end

      if (!w_run) begin
        for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
        r_ch_ptr   <= '0;
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else if (!full_i) begin
        r_phase[r_ch_ptr] <= w_p + r_step[r_ch_ptr];
        r_ch_ptr   <= (r_ch_ptr == CH_W'(NUM_CH - 1)) ? '0 : r_ch_ptr + 1'b1;
        r_s1_valid <= r_en[r_ch_ptr];
        r_s1_ch    <= r_ch_ptr;
        r_s1_sel   <= r_sel[r_ch_ptr];
        r_s1_amp   <= r_amp[r_ch_ptr];
        r_s1_u     <= w_p[PHASE_WIDTH-1 -: DATA_WIDTH];
        r_s2_valid <= r_s1_valid;
        r_s2_ch    <= r_s1_ch;
        r_s2_data  <= w_sat;
      end
    end
  end

  assign wr_en_o = r_s2_valid & !full_i;
  assign data_o  = r_s2_data;
  assign ch_o    = r_s2_ch;

endmodule

// File: tb/tb_funct_generator_mc.sv
// tb/tb_funct_generator_mc.sv - directed self-checking bench for funct_generator_mc
module tb_funct_generator_mc;

  logic              clk = 1'b0;
  logic              rst, en_low_i, enh_conf_i, cfg_we_i, cfg_en_i, full_i;
  logic [0:0]        cfg_ch_i;
  logic [1:0]        cfg_sel_i;
  logic [7:0]        cfg_amp_i;
  logic [15:0]       cfg_step_i;
  logic              wr_en_o;
  logic signed [15:0] data_o;
  logic [0:0]        ch_o;

  int n_checks = 0;
  int n_errors = 0;
  int widx     = 0;
  int held     = 0;
  int nw       = 0;
  int seq [4]  = '{32511, 32511, -32512, -32512};

  always #5 clk = ~clk;

  funct_generator_mc dut (
    .clk        (clk),
    .rst        (rst),
    .en_low_i   (en_low_i),
    .enh_conf_i (enh_conf_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_sel_i  (cfg_sel_i),
    .cfg_amp_i  (cfg_amp_i),
    .cfg_step_i (cfg_step_i),
    .cfg_en_i   (cfg_en_i),
    .full_i     (full_i),
    .wr_en_o    (wr_en_o),
    .data_o     (data_o),
    .ch_o       (ch_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto_conf();
    @(negedge clk);
    en_low_i   = 1'b1;
    enh_conf_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cfg(input logic ch, input logic [1:0] sel, input logic [7:0] amp,
                     input logic [15:0] step, input logic en);
    cfg_we_i   = 1'b1;
    cfg_ch_i   = ch;
    cfg_sel_i  = sel;
    cfg_amp_i  = amp;
    cfg_step_i = step;
    cfg_en_i   = en;
    @(negedge clk);
    cfg_we_i   = 1'b0;
  endtask

  task automatic start_gen();
    enh_conf_i = 1'b0;
    en_low_i   = 1'b0;
  endtask

  task automatic sample_write(input string tag);
    if (wr_en_o) begin
      check(tag, data_o, seq[widx % 4]);
      check({tag, "_ch"}, ch_o, 0);
      widx++;
    end
  endtask

  task automatic run_const(input string tag, input int exp_data);
    nw = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (wr_en_o) begin
        check(tag, data_o, exp_data);
        nw++;
      end
    end
    check({tag, "_cnt"}, nw, 5);
  endtask

  initial begin
    rst = 1'b1; en_low_i = 1'b0; enh_conf_i = 1'b0; cfg_we_i = 1'b0; cfg_en_i = 1'b0;
    full_i = 1'b0; cfg_ch_i = '0; cfg_sel_i = '0; cfg_amp_i = '0; cfg_step_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr", wr_en_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ch", ch_o, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_idle_wr", wr_en_o, 0);
    end

    // Square stream with a 3-cycle stall in the middle
    goto_conf();
    cfg(1'b0, 2'd3, 8'd127, 16'h4000, 1'b1);
    cfg(1'b1, 2'd0, 8'd0, 16'h0000, 1'b0);
    start_gen();
    widx = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      full_i = (k >= 20 && k <= 22);
      #1;
      if (k < 20) begin
        check("sq_cadence", wr_en_o, (k >= 4 && k % 2 == 0) ? 1 : 0);
        sample_write("sq_data");
      end else if (k <= 22) begin
        if (k == 20) held = data_o;
        check("stall_wr", wr_en_o, 0);
        check("stall_hold", data_o, held);
      end else begin
        sample_write("sq_resume");
      end
    end
    check("sq_total", widx, 17);

    // Config writes outside CONFI must be ignored
    nw = widx;
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_ch_i = 1'b0; cfg_sel_i = 2'd3; cfg_amp_i = 8'd0;
    cfg_step_i = 16'h4000; cfg_en_i = 1'b1;
    #1;
    sample_write("ign_data");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cfg_we_i = 1'b0;
      #1;
      sample_write("ign_data");
    end
    check("ign_cnt", widx - nw, 5);

    // Leaving GEN kills output at once; re-entry restarts at phase 0
    @(negedge clk);
    en_low_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("exit_wr", wr_en_o, 0);
    end
    @(negedge clk);
    en_low_i = 1'b0;
    widx = 0;
    #1;
    check("reent_wr0", wr_en_o, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      check("reent_cadence", wr_en_o, (k >= 3 && (k - 3) % 2 == 0) ? 1 : 0);
      sample_write("reent_data");
    end

    goto_conf();
    cfg(1'b0, 2'd2, 8'h80, 16'h0000, 1'b1);
    start_gen();
    run_const("sat", 32767);

    goto_conf();
    cfg(1'b0, 2'd1, 8'd127, 16'h0000, 1'b1);
    start_gen();
    run_const("cos", 32511);

    goto_conf();
    cfg(1'b0, 2'd0, 8'd127, 16'h0000, 1'b1);
    start_gen();
    run_const("sin", 0);

    // Reset in the middle of a running stream
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_wr", wr_en_o, 0);
    check("midrst_data", data_o, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/funct_generator_mc.md
Name: funct_generator_mc

Overview:
- Multi-channel successor of the single-channel LUT function generator.
- Each of NUM_CH channels has its own phase accumulator with a programmable step, its own waveform select, amplitude and enable.
- Channels are time-multiplexed round-robin into one sample stream that drives a downstream FIFO write port, with backpressure from the FIFO full flag.
- The block sits between the configuration inputs and the output FIFO, in the same position as the existing generator.

Parameters:
- DATA_WIDTH, 16, sample width (signed).
- AMP_WIDTH, 8, amplitude width (signed); full scale is 2**(AMP_WIDTH-1)-1.
- LUT_ADDR, 8, sine ROM address width.
- PHASE_WIDTH, 16, phase accumulator width; must be >= DATA_WIDTH and >= LUT_ADDR.
- NUM_CH, 2, channel count; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en_low_i  in  1  active-low run request.
- enh_conf_i  in  1  configuration mode request.
- cfg_we_i  in  1  write one channel's configuration.
- cfg_ch_i  in  $clog2(NUM_CH)  target channel.
- cfg_sel_i  in  2  waveform: 0 sine, 1 cosine, 2 triangle, 3 square.
- cfg_amp_i  in  AMP_WIDTH  signed amplitude.
- cfg_step_i  in  PHASE_WIDTH  phase increment.
- cfg_en_i  in  1  channel enable.
- full_i  in  1  downstream FIFO full.
- wr_en_o  out  1  sample write strobe.
- data_o  out  DATA_WIDTH  signed sample.
- ch_o  out  $clog2(NUM_CH)  source channel of data_o.

Behaviour:
- Reset: state IDLE; all phases, steps, amplitudes, selects and enables = 0; ch_ptr = 0; pipeline valids = 0; wr_en_o = 0, data_o = 0, ch_o = 0. Reset mid-operation discards in-flight samples.
- FSM (IDLE, CONFI, GEN):
  - IDLE: enh_conf_i -> CONFI; else !en_low_i -> GEN; else stay.
  - CONFI: !enh_conf_i -> IDLE.
  - GEN: enh_conf_i or en_low_i -> IDLE.
- Phase accumulators and ch_ptr are held at 0 while state != GEN. Re-entering GEN always restarts at phase 0, channel 0.
- Configuration:
  - cfg_we_i is honoured only in CONFI and writes sel/amp/step/en of cfg_ch_i in one cycle.
  - Writes in other states are ignored.
  - cfg_ch_i >= NUM_CH is ignored.
- Issue (stage 0), only in GEN with full_i = 0:
  - Sample channel ch_ptr at its current phase p.
  - Then phase[ch_ptr] <= p + step, wrapping mod 2**PHASE_WIDTH.
  - ch_ptr advances, wrapping at NUM_CH-1.
  - A disabled channel still consumes its slot and advances its phase, but issues valid = 0 (no write).
- Wave generation (registered, stage 1); u = p[PHASE_WIDTH-1 -: DATA_WIDTH]:
  - Sine: ROM[p[PHASE_WIDTH-1 -: LUT_ADDR]].
  - Cosine: ROM[that address + 2**(LUT_ADDR-2)], wrapping.
  - Triangle: t = u[MSB] ? ~u[DATA_WIDTH-2:0] : u[DATA_WIDTH-2:0]; wave = {t,1'b0} - 2**(DATA_WIDTH-1).
  - Square: u[MSB] = 0 -> +(2**(DATA_WIDTH-1)-1), else -(2**(DATA_WIDTH-1)-1).
  - ROM[k] = round((2**(DATA_WIDTH-1)-1) * sin(2*pi*k / 2**LUT_ADDR)).
- Scale (registered, stage 2):
  - prod = wave * amp, full width DATA_WIDTH+AMP_WIDTH, signed.
  - res = prod >>> (AMP_WIDTH-1), arithmetic shift (floor).
  - res is saturated to the signed DATA_WIDTH range.
- Output:
  - wr_en_o = s2_valid & !full_i (combinational gate).
  - data_o and ch_o come from stage-2 registers.
- Latency: a sample issued in cycle n appears with wr_en_o in cycle n+2 when there is no stall.
- Backpressure: full_i = 1 freezes issue, all pipeline registers and phases; wr_en_o = 0. No sample is lost or duplicated.
- Leaving GEN clears all pipeline valids on the same clock edge. wr_en_o = 0 from the first cycle state != GEN.

Decomposition:
- fifo_defines_pkg gains: state_t enum (IDLE, CONFI, GEN); wave_sel_t enum (SINE, COSINE, TRIANGLE, SQUARE); defaults for NUM_CH, PHASE_WIDTH, AMP_WIDTH.
- One sub-module, funct_gen_wave_rom: synchronous dual-read sine ROM (sine and cosine addresses), parametrised by LUT_ADDR and DATA_WIDTH.

Test Plan:
All scenarios use default parameters.
- Reset: rst = 1 for 2 cycles with en_low_i = 0 -> wr_en_o = 0, data_o = 0, ch_o = 0; state reaches GEN only on the first cycle after rst drops.
- Square sequence: CONFI writes ch0 {sel 3, amp 127, step 0x4000, en 1}, ch1 en 0; then GEN with full_i = 0 -> ch0 writes every 2nd cycle with data 32511, 32511, -32512, -32512, repeating; ch_o = 0; no ch1 writes.
- Saturation: ch0 {sel 2, amp -128, step 0}, GEN -> tri = -32768, prod = 4194304, data_o = 32767 on every write.
- Cosine: ch0 {sel 1, amp 127, step 0} -> data_o = 32511; with sel 0 the same setup gives data_o = 0.
- Backpressure: square stream running, full_i = 1 for 3 cycles mid-stream -> wr_en_o = 0 and data_o held during the stall; the sequence resumes with the next expected value, none skipped or repeated.
- Mode exit and ignored config: in GEN, pulse cfg_we_i with amp 0 -> output unchanged. Raise en_low_i -> wr_en_o = 0 the next cycle. Lower en_low_i -> the first sample again reflects phase 0 (32511 for the square setup).
